// File: rtl/leap_ram_responder.sv
// leap_ram_responder
//
// Memory-side responder for the dual-port RAM interface used by the kernel
// memory wrappers. It holds the word array and returns read data after a fixed
// READ_LATENCY. It also produces a periodic waitrequest pattern, which kernels
// see as memory_controller_waitrequest and which lets a bench exercise their
// stall paths.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   en_x / we_x           access enable / write enable for port x (a or b)
//   addr_x, in_x          word address and write data
//   byteena_x             write mask; 0 suppresses the write
//   out_x                 read data; holds until the next read result lands
//   waitrequest           stall; no request is accepted while it is high
//   rd_count / wr_count   saturating counts of accepted reads / writes
//   collision             one-cycle pulse after a same-address write/write
module leap_ram_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1,
    parameter int STALL_PERIOD = 0,
    parameter int STALL_LEN    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic                  byteena_a,
    output logic [DATA_WIDTH-1:0] out_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  byteena_b,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic                  waitrequest,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count,
    output logic                  collision
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    // Index 0 is port a and index 1 is port b. This lets both ports share one description.
    logic [1:0]            en, we, be;
    logic [1:0]            in_range, acc, rd, wr, wr_ok;
    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [DATA_WIDTH-1:0] rdata [2];
    logic [IDX_W-1:0]      idx   [2];

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign en       = {en_b, en_a};
    assign we       = {we_b, we_a};
    assign be       = {byteena_b, byteena_a};
    assign addr[0]  = addr_a;
    assign addr[1]  = addr_b;
    assign wdata[0] = in_a;
    assign wdata[1] = in_b;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        in_range = '0;
        acc      = '0;
        rd       = '0;
        wr       = '0;
        wr_ok    = '0;
        for (int p = 0; p < 2; p++) begin
            in_range[p] = ({1'b0, addr[p]} < DEPTH_C);
            acc[p]      = en[p] & ~waitrequest;
            rd[p]       = acc[p] & ~we[p];
            wr[p]       = acc[p] & we[p] & be[p];
            wr_ok[p]    = wr[p] & in_range[p];
        end
    end

    // Out-of-range reads return zero but still flow through the pipeline.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        assign idx[p]   = addr[p][IDX_W-1:0];
        assign rdata[p] = in_range[p] ? mem[idx[p]] : '0;
    end

    // Port b is written first and port a second, so port a's data wins on a
    // same-address collision. A read samples the array in the same cycle, so it
    // sees the old contents.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset, so contents written before a reset survive it; state updates use non-blocking assignments throughout.
        if (!reset) begin
            if (wr_ok[1]) mem[idx[1]] <= wdata[1];
            if (wr_ok[0]) mem[idx[0]] <= wdata[0];
        end
    end

    function automatic logic [31:0] sat_add(logic [31:0] c, logic [1:0] n);
        logic [32:0] s;
        s = {1'b0, c} + {31'b0, n};
        return s[32] ? '1 : s[31:0];
    endfunction

    logic [1:0] n_rd, n_wr;
    assign n_rd = {1'b0, rd[0]} + {1'b0, rd[1]};
    assign n_wr = {1'b0, wr[0]} + {1'b0, wr[1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count  <= '0;
            wr_count  <= '0;
            collision <= 1'b0;
        end else begin
            rd_count  <= sat_add(rd_count, n_rd);
            wr_count  <= sat_add(wr_count, n_wr);
            collision <= wr_ok[0] & wr_ok[1] & (addr[0] == addr[1]);
        end
    end

    // Read pipeline per port. A sample accepted in cycle t reaches out after
    // READ_LATENCY edges that are not stalled. With READ_LATENCY = 1, out is
    // loaded directly from the array.
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  head_v;
        logic [DATA_WIDTH-1:0] head_d;
        logic [DATA_WIDTH-1:0] out_q;

        if (READ_LATENCY == 1) begin : g_direct
            assign head_v = rd[p];
            assign head_d = rdata[p];
        end else begin : g_pipe
            logic [READ_LATENCY-2:0] v_q;
            logic [DATA_WIDTH-1:0]   d_q [READ_LATENCY-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    v_q <= '0;
                end else if (!waitrequest) begin
                    v_q[0] <= rd[p];
                    d_q[0] <= rdata[p];
                    for (int i = 1; i < READ_LATENCY - 1; i++) begin
                        v_q[i] <= v_q[i-1];
                        d_q[i] <= d_q[i-1];
                    end
                end
            end

            assign head_v = v_q[READ_LATENCY-2];
            assign head_d = d_q[READ_LATENCY-2];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                out_q <= '0;
            end else if (!waitrequest && head_v) begin
                out_q <= head_d;
            end
        end
    end

    assign out_a = g_port[0].out_q;
    assign out_b = g_port[1].out_q;

    // Stall generator. waitrequest is decoded from a free-running registered
    // counter, so it changes only on clock edges.
    if (STALL_PERIOD == 0) begin : g_no_stall
        assign waitrequest = 1'b0;
    end else begin : g_stall
        localparam int CW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
        logic [CW-1:0] cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt <= '0;
            end else if (cnt == CW'(STALL_PERIOD - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end

        assign waitrequest = (cnt >= CW'(STALL_PERIOD - STALL_LEN));
    end

endmodule

// File: tb/tb_leap_ram_responder.sv
// Testbench for leap_ram_responder. It instantiates three configurations:
//   dut 0: DEPTH 1000, latency 1, no stalls (RAW, collision, boundaries)
//   dut 1: DEPTH 1024, latency 3, no stalls (latency sweep)
//   dut 2: DEPTH 1024, latency 2, stall period 4 / length 1 (stalls, reset)
// Stimulus pushes expected values, tagged with the cycle they are due, into a
// scoreboard. A monitor on the falling edge compares every entry that falls due.
module tb_leap_ram_responder;

    localparam int DW = 32;
    localparam int AW = 10;

    localparam int F_OUT_A = 0;
    localparam int F_OUT_B = 1;
    localparam int F_WAIT  = 2;
    localparam int F_RDCNT = 3;
    localparam int F_WRCNT = 4;
    localparam int F_COLL  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst         [3];
    logic          en_a        [3];
    logic          we_a        [3];
    logic          byteena_a   [3];
    logic          en_b        [3];
    logic          we_b        [3];
    logic          byteena_b   [3];
    logic [AW-1:0] addr_a      [3];
    logic [AW-1:0] addr_b      [3];
    logic [DW-1:0] in_a        [3];
    logic [DW-1:0] in_b        [3];
    logic [DW-1:0] out_a       [3];
    logic [DW-1:0] out_b       [3];
    logic          waitrequest [3];
    logic          collision   [3];
    logic [31:0]   rd_count    [3];
    logic [31:0]   wr_count    [3];

    leap_ram_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1000), .READ_LATENCY(1),
                         .STALL_PERIOD(0), .STALL_LEN(1)) dut0 (
        .clk(clk), .reset(rst[0]),
        .en_a(en_a[0]), .we_a(we_a[0]), .addr_a(addr_a[0]), .in_a(in_a[0]),
        .byteena_a(byteena_a[0]), .out_a(out_a[0]),
        .en_b(en_b[0]), .we_b(we_b[0]), .addr_b(addr_b[0]), .in_b(in_b[0]),
        .byteena_b(byteena_b[0]), .out_b(out_b[0]),
        .waitrequest(waitrequest[0]), .rd_count(rd_count[0]), .wr_count(wr_count[0]),
        .collision(collision[0]));

    leap_ram_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1024), .READ_LATENCY(3),
                         .STALL_PERIOD(0), .STALL_LEN(1)) dut1 (
        .clk(clk), .reset(rst[1]),
        .en_a(en_a[1]), .we_a(we_a[1]), .addr_a(addr_a[1]), .in_a(in_a[1]),
        .byteena_a(byteena_a[1]), .out_a(out_a[1]),
        .en_b(en_b[1]), .we_b(we_b[1]), .addr_b(addr_b[1]), .in_b(in_b[1]),
        .byteena_b(byteena_b[1]), .out_b(out_b[1]),
        .waitrequest(waitrequest[1]), .rd_count(rd_count[1]), .wr_count(wr_count[1]),
        .collision(collision[1]));

    leap_ram_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1024), .READ_LATENCY(2),
                         .STALL_PERIOD(4), .STALL_LEN(1)) dut2 (
        .clk(clk), .reset(rst[2]),
        .en_a(en_a[2]), .we_a(we_a[2]), .addr_a(addr_a[2]), .in_a(in_a[2]),
        .byteena_a(byteena_a[2]), .out_a(out_a[2]),
        .en_b(en_b[2]), .we_b(we_b[2]), .addr_b(addr_b[2]), .in_b(in_b[2]),
        .byteena_b(byteena_b[2]), .out_b(out_b[2]),
        .waitrequest(waitrequest[2]), .rd_count(rd_count[2]), .wr_count(wr_count[2]),
        .collision(collision[2]));

    // Cycle index: it increments on each rising edge. A request driven in
    // cycle c with latency L is expected to be visible in cycle c+L.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] actual(int sig);
        int d;
        d = sig / 8;
        case (sig % 8)
            F_OUT_A: return out_a[d];
            F_OUT_B: return out_b[d];
            F_WAIT:  return {31'b0, waitrequest[d]};
            F_RDCNT: return rd_count[d];
            F_WRCNT: return wr_count[d];
            F_COLL:  return {31'b0, collision[d]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic expect_at(int due, int d, int f, logic [31:0] v, string name);
        exp_t e;
        e.due  = due;
        e.sig  = d * 8 + f;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compares every scoreboard entry whose cycle has arrived.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check(sb[i].name, actual(sb[i].sig), sb[i].exp);
                sb.delete(i);
            end else if (sb[i].due < cyc) begin
                n_checks++;
                $display("FAIL %s: due in cycle %0d, never compared (now %0d)",
                         sb[i].name, sb[i].due, cyc);
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int d,
                         logic ea, logic wa, logic [AW-1:0] aa, logic [DW-1:0] da, logic ba,
                         logic eb, logic wb, logic [AW-1:0] ab, logic [DW-1:0] db, logic bb);
        en_a[d] = ea; we_a[d] = wa; addr_a[d] = aa; in_a[d] = da; byteena_a[d] = ba;
        en_b[d] = eb; we_b[d] = wb; addr_b[d] = ab; in_b[d] = db; byteena_b[d] = bb;
    endtask

    task automatic idle(int d);
        drive(d, 1'b0, 1'b0, 'x, 'x, 1'b0, 1'b0, 1'b0, 'x, 'x, 1'b0);
    endtask

    // Kernel-style requester on dut 2, port a. It holds the request until a cycle without waitrequest accepts it.
    task automatic k_req(logic w, logic [AW-1:0] a, logic [DW-1:0] dv);
        int n;
        n = 0;
        drive(2, 1'b1, w, a, dv, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        while (waitrequest[2] && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) begin
            n_checks++;
            $display("FAIL k_req_timeout: waitrequest high for %0d cycles, expected low within 8", n);
        end
        tick();
    endtask

    function automatic logic [31:0] word_val(int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    // Expected out_a of dut 2 for cycles 0..13 after reset release. Reads of
    // addresses 0..7 go out with latency 2, and stalls fall in cycles 3, 7, 11.
    // An entry of -1 means out_a is still 0.
    int stall_out_idx [14] = '{-1, -1, 0, 1, 1, 2, 3, 4, 4, 5, 6, 7, 7, 7};

    int c, t, r_rel, guard;

    initial begin
        for (int d = 0; d < 3; d++) begin
            idle(d);
            rst[d] = 1'b1;
        end
        repeat (3) tick();
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // Reset state.
        c = cyc;
        expect_at(c, 0, F_OUT_A, 32'h0, "reset_out_a");
        expect_at(c, 0, F_OUT_B, 32'h0, "reset_out_b");
        expect_at(c, 0, F_RDCNT, 32'h0, "reset_rd_count");
        expect_at(c, 0, F_WRCNT, 32'h0, "reset_wr_count");
        expect_at(c, 0, F_COLL,  32'h0, "reset_collision");
        expect_at(c, 1, F_OUT_A, 32'h0, "reset_out_a_lat3");
        expect_at(c, 2, F_WAIT,  32'h0, "reset_waitrequest");

        // ---- dut 0: latency 1 ----
        drive(0, 1, 1, 10'd5, 32'hDEADBEEF, 1, 0, 0, '0, '0, 0); tick();
        c = cyc;
        drive(0, 1, 0, 10'd5, '0, 1, 0, 0, '0, '0, 0);
        expect_at(c + 1, 0, F_OUT_A, 32'hDEADBEEF, "lat1_out_a");
        expect_at(c + 1, 0, F_OUT_B, 32'h0, "lat1_out_b_untouched");
        tick();

        // Cross-port read-during-write returns old data.
        drive(0, 1, 1, 10'd7, 32'h11, 1, 0, 0, '0, '0, 0); tick();
        c = cyc;
        drive(0, 1, 1, 10'd7, 32'h22, 1, 1, 0, 10'd7, '0, 0);
        expect_at(c + 1, 0, F_OUT_B, 32'h11, "raw_old_data");
        tick();
        c = cyc;
        drive(0, 0, 0, '0, '0, 0, 1, 0, 10'd7, '0, 0);
        expect_at(c + 1, 0, F_OUT_B, 32'h22, "raw_new_data");
        expect_at(c + 1, 0, F_OUT_A, 32'hDEADBEEF, "out_a_hold");
        tick();

        // Both ports read the same address.
        c = cyc;
        drive(0, 1, 0, 10'd5, '0, 0, 1, 0, 10'd5, '0, 0);
        expect_at(c + 1, 0, F_OUT_A, 32'hDEADBEEF, "dual_read_a");
        expect_at(c + 1, 0, F_OUT_B, 32'hDEADBEEF, "dual_read_b");
        tick();

        // Write/write collision; port a wins. Earlier writes: 5, 7, 7.
        c = cyc;
        drive(0, 1, 1, 10'd3, 32'hAAAA, 1, 1, 1, 10'd3, 32'hBBBB, 1);
        expect_at(c, 0, F_COLL, 32'h0, "collision_quiet");
        expect_at(c + 1, 0, F_COLL, 32'h1, "collision_pulse");
        expect_at(c + 1, 0, F_WRCNT, 32'd5, "wr_count_after_collision");
        tick();
        c = cyc;
        drive(0, 1, 0, 10'd3, '0, 0, 0, 0, '0, '0, 0);
        expect_at(c + 1, 0, F_OUT_A, 32'hAAAA, "collision_a_wins");
        expect_at(c + 1, 0, F_COLL, 32'h0, "collision_one_cycle");
        tick();
        c = cyc;
        idle(0);
        expect_at(c + 1, 0, F_OUT_A, 32'hAAAA, "idle_x_no_effect");
        tick();

        // Out-of-range write is dropped; out-of-range read returns 0.
        drive(0, 1, 1, 10'd999, 32'h777, 1, 0, 0, '0, '0, 0); tick();
        drive(0, 1, 1, 10'd1000, 32'h5, 1, 0, 0, '0, '0, 0); tick();
        c = cyc;
        drive(0, 1, 0, 10'd1000, '0, 0, 1, 0, 10'd999, '0, 0);
        expect_at(c + 1, 0, F_OUT_A, 32'h0, "oor_read_zero");
        expect_at(c + 1, 0, F_OUT_B, 32'h777, "mem999_intact");
        tick();

        // byteena = 0 suppresses the write.
        drive(0, 1, 1, 10'd2, 32'h1234, 1, 0, 0, '0, '0, 0); tick();
        drive(0, 1, 1, 10'd2, 32'h9, 0, 0, 0, '0, '0, 0); tick();
        c = cyc;
        drive(0, 1, 0, 10'd2, '0, 0, 0, 0, '0, '0, 0);
        expect_at(c + 1, 0, F_OUT_A, 32'h1234, "byteena0_no_write");
        expect_at(c + 1, 0, F_RDCNT, 32'd9, "rd_count_total");
        tick();
        idle(0);

        // ---- dut 1: latency 3 ----
        drive(1, 1, 1, 10'd6, 32'h6666, 1, 0, 0, '0, '0, 0); tick();
        drive(1, 1, 1, 10'd5, 32'hDEADBEEF, 1, 0, 0, '0, '0, 0); tick();
        c = cyc;
        drive(1, 1, 0, 10'd6, '0, 0, 0, 0, '0, '0, 0);
        expect_at(c + 2, 1, F_OUT_A, 32'h0, "lat3_not_early");
        expect_at(c + 3, 1, F_OUT_A, 32'h6666, "lat3_first");
        tick();
        idle(1);
        repeat (3) tick();
        t = cyc;
        drive(1, 1, 0, 10'd5, '0, 0, 0, 0, '0, '0, 0);
        expect_at(t + 1, 1, F_OUT_A, 32'h6666, "lat3_hold_t1");
        expect_at(t + 2, 1, F_OUT_A, 32'h6666, "lat3_hold_t2");
        expect_at(t + 3, 1, F_OUT_A, 32'hDEADBEEF, "lat3_data");
        expect_at(t + 3, 1, F_OUT_B, 32'h0, "lat3_out_b_untouched");
        tick();
        idle(1);

        // ---- dut 2: stalls and reset ----
        for (int i = 0; i < 8; i++) k_req(1'b1, AW'(i), word_val(i));
        idle(2);
        tick();
        rst[2] = 1'b1;
        tick();
        tick();
        rst[2] = 1'b0;
        c = cyc;
        for (int rel = 0; rel < 14; rel++) begin
            expect_at(c + rel, 2, F_WAIT, (rel % 4 == 3) ? 32'h1 : 32'h0,
                      $sformatf("stall_wait_rel%0d", rel));
            expect_at(c + rel, 2, F_OUT_A,
                      (stall_out_idx[rel] < 0) ? 32'h0 : word_val(stall_out_idx[rel]),
                      $sformatf("stall_out_a_rel%0d", rel));
        end
        expect_at(c + 12, 2, F_RDCNT, 32'd8, "stall_rd_count");
        expect_at(c + 14, 2, F_OUT_A, word_val(7), "pre_reset_hold");
        for (int k = 15; k <= 20; k++)
            expect_at(c + k, 2, F_OUT_A, 32'h0, $sformatf("post_reset_out_zero_%0d", k - 15));
        for (int k = 15; k <= 19; k++)
            expect_at(c + k, 2, F_WAIT, ((k - 15) % 4 == 3) ? 32'h1 : 32'h0,
                      $sformatf("post_reset_wait_rel%0d", k - 15));
        expect_at(c + 15, 2, F_RDCNT, 32'h0, "post_reset_rd_count");

        for (int i = 0; i < 8; i++) k_req(1'b0, AW'(i), '0);
        idle(2);
        r_rel = 0;
        while (cyc < c + 13 && r_rel < 20) begin
            tick();
            r_rel++;
        end
        // A read in cycle 13 (not stalled); reset in cycle 14 discards it.
        drive(2, 1, 0, 10'd5, '0, 1, 0, 0, '0, '0, 0);
        tick();
        idle(2);
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        repeat (6) tick();

        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            tick();
            guard++;
        end
        foreach (sb[i]) begin
            n_checks++;
            $display("FAIL %s: still pending at end of run (due cycle %0d)", sb[i].name, sb[i].due);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
